// File: rtl/vga_scan_pipeline_if.sv
// Framebuffer read port of the VGA scan-out engine.
// master: fb_rd_addr/fb_rd_en out, fb_rd_data in; slave: the reverse.
interface vga_scan_pipeline_if #(
  parameter int ADDR_W = 19,
  parameter int IDX_W  = 3
);
  logic [ADDR_W-1:0] fb_rd_addr;
  logic              fb_rd_en;
  logic [IDX_W-1:0]  fb_rd_data;

  modport master (
    output fb_rd_addr,
    output fb_rd_en,
    input  fb_rd_data
  );

  modport slave (
    input  fb_rd_addr,
    input  fb_rd_en,
    output fb_rd_data
  );
endinterface

// File: rtl/vga_scan_pipeline.sv
// VGA scan-out: timing, indexed framebuffer fetch, palette, overlay rects.
// Ports: iVGA_CLK/iRST_n, fb (read bus), pal_wr_*, rect_wr_*, oHS/oVS/oBLANK_n,
// b/g/r_data, frame_start. `VGA_SCAN_DOUBLE_EN selects 2x pixel doubling.
module vga_scan_pipeline #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IDX_W    = 3,
  parameter int COLOR_W  = 8,
  parameter int RD_LAT   = 2,
  parameter int NUM_RECT = 4,
  parameter int ADDR_W   = 19
) (
  input  logic                   iVGA_CLK,
  input  logic                   iRST_n,
  vga_scan_pipeline_if.master    fb,
  input  logic                   pal_wr_en,
  input  logic [IDX_W-1:0]       pal_wr_idx,
  input  logic [3*COLOR_W-1:0]   pal_wr_bgr,
  input  logic                   rect_wr_en,
  input  logic [2:0]             rect_wr_sel,
  input  logic [41+IDX_W-1:0]    rect_wr_data,
  output logic                   oHS,
  output logic                   oVS,
  output logic                   oBLANK_n,
  output logic [COLOR_W-1:0]     b_data,
  output logic [COLOR_W-1:0]     g_data,
  output logic [COLOR_W-1:0]     r_data,
  output logic                   frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int L       = RD_LAT + 1;
  localparam int PAL_N   = 1 << IDX_W;
  localparam int RW      = 41 + IDX_W;
  localparam int CW      = 3 * COLOR_W;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  int            hx, vy;
  logic          h_end, v_end;
  logic          active, commit;
  logic          hs_raw, vs_raw;

  assign hx     = int'(h_cnt_q);
  assign vy     = int'(v_cnt_q);
  assign h_end  = (hx == H_TOTAL - 1);
  assign v_end  = (vy == V_TOTAL - 1);
  assign active = (hx < H_ACTIVE) && (vy < V_ACTIVE);
  assign commit = (hx == 0) && (vy == V_ACTIVE);
  assign hs_raw = !((hx >= H_ACTIVE + H_FP) &&
                    (hx <  H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw = !((vy >= V_ACTIVE + V_FP) &&
                    (vy <  V_ACTIVE + V_FP + V_SYNC));

  always_comb begin
    h_cnt_d = h_end ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_end)
      v_cnt_d = v_end ? '0 : v_cnt_q + VW'(1);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Address of the pixel at the current counters, built without a multiply.
  logic [ADDR_W-1:0] addr_q, addr_d;

`ifdef VGA_SCAN_DOUBLE_EN
  logic [ADDR_W-1:0] base_q, base_d;

  // Each source line is shown twice, so the base steps after odd lines.
  always_comb begin
    base_d = base_q;
    if (h_end) begin
      if (v_end)
        base_d = '0;
      else if (v_cnt_q[0] && (vy < V_ACTIVE))
        base_d = base_q + ADDR_W'(H_ACTIVE / 2);
    end
    addr_d = base_d + ADDR_W'(h_cnt_d >> 1);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) base_q <= '0;
    else         base_q <= base_d;
  end
`else
  always_comb begin
    addr_d = addr_q;
    if (h_end && v_end)
      addr_d = '0;
    else if (active)
      addr_d = addr_q + ADDR_W'(1);
  end
`endif

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) addr_q <= '0;
    else         addr_q <= addr_d;
  end

  // Counters sit at (0,0) during reset; the gate keeps reads off until release.
  assign fb.fb_rd_addr = addr_q;
  assign fb.fb_rd_en   = active & iRST_n;
  assign frame_start   = commit;

  logic [CW-1:0] pal_sh_q  [PAL_N];
  logic [CW-1:0] pal_lv_q  [PAL_N];
  logic [RW-1:0] rect_sh_q [NUM_RECT];
  logic [RW-1:0] rect_lv_q [NUM_RECT];

  // Live copies take the shadow value from before any same-cycle write.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < PAL_N; i++) begin
        pal_sh_q[i] <= '0;
        pal_lv_q[i] <= '0;
      end
      for (int i = 0; i < NUM_RECT; i++) begin
        rect_sh_q[i] <= '0;
        rect_lv_q[i] <= '0;
      end
    end else begin
      if (commit) begin
        for (int i = 0; i < PAL_N; i++)
          pal_lv_q[i] <= pal_sh_q[i];
        for (int i = 0; i < NUM_RECT; i++)
          rect_lv_q[i] <= rect_sh_q[i];
      end
      if (pal_wr_en)
        pal_sh_q[pal_wr_idx] <= pal_wr_bgr;
      for (int i = 0; i < NUM_RECT; i++)
        if (rect_wr_en && (rect_wr_sel == 3'(i)))
          rect_sh_q[i] <= rect_wr_data;
    end
  end

  function automatic logic rect_hit(
    input logic [RW-1:0] r,
    input int            x,
    input int            y
  );
    int x0, y0, x1, y1;
    x0 = int'(r[IDX_W+30 +: 10]);
    y0 = int'(r[IDX_W+20 +: 10]);
    x1 = int'(r[IDX_W+10 +: 10]);
    y1 = int'(r[IDX_W    +: 10]);
    return r[RW-1] && (x >= x0) && (x <= x1) &&
           (y >= y0) && (y <= y1);
  endfunction

  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  // Walk from the top so the lowest-numbered hit is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (rect_hit(rect_lv_q[i], hx, vy)) begin
        hit     = 1'b1;
        hit_idx = rect_lv_q[i][IDX_W-1:0];
      end
    end
  end

  logic [IDX_W:0] sel_sr_q [RD_LAT];
  logic [L-1:0]   hs_sr_q, vs_sr_q, bl_sr_q;
  logic [CW-1:0]  col_q;
  logic [IDX_W-1:0] pix_idx;

  assign pix_idx = sel_sr_q[RD_LAT-1][IDX_W] ?
                   sel_sr_q[RD_LAT-1][IDX_W-1:0] : fb.fb_rd_data;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < RD_LAT; i++)
        sel_sr_q[i] <= '0;
      hs_sr_q <= '1;
      vs_sr_q <= '1;
      bl_sr_q <= '0;
      col_q   <= '0;
    end else begin
      sel_sr_q[0] <= {hit, hit_idx};
      for (int i = 1; i < RD_LAT; i++)
        sel_sr_q[i] <= sel_sr_q[i-1];
      hs_sr_q[0] <= hs_raw;
      vs_sr_q[0] <= vs_raw;
      bl_sr_q[0] <= active;
      for (int i = 1; i < L; i++) begin
        hs_sr_q[i] <= hs_sr_q[i-1];
        vs_sr_q[i] <= vs_sr_q[i-1];
        bl_sr_q[i] <= bl_sr_q[i-1];
      end
      col_q <= bl_sr_q[RD_LAT-1] ? pal_lv_q[pix_idx] : '0;
    end
  end

  assign oHS      = hs_sr_q[L-1];
  assign oVS      = vs_sr_q[L-1];
  assign oBLANK_n = bl_sr_q[L-1];
  assign b_data   = col_q[CW-1 -: COLOR_W];
  assign g_data   = col_q[2*COLOR_W-1 -: COLOR_W];
  assign r_data   = col_q[COLOR_W-1:0];
endmodule

// File: tb/tb_vga_scan_pipeline.sv
// Randomised bench for vga_scan_pipeline with a frame-level reference model.
// Small timing parameters keep several whole frames within a short run.
module tb_vga_scan_pipeline;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int IW = 3, CWD = 8, RL = 2, NR = 4, AW = 19;
  localparam int L  = RL + 1;
  localparam int RW = 41 + IW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              pal_wr_en;
  logic [IW-1:0]     pal_wr_idx;
  logic [3*CWD-1:0]  pal_wr_bgr;
  logic              rect_wr_en;
  logic [2:0]        rect_wr_sel;
  logic [RW-1:0]     rect_wr_data;
  logic              oHS, oVS, oBLANK_n, frame_start;
  logic [CWD-1:0]    b_data, g_data, r_data;

  vga_scan_pipeline_if #(.ADDR_W(AW), .IDX_W(IW)) fb ();

  vga_scan_pipeline #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IDX_W(IW), .COLOR_W(CWD), .RD_LAT(RL),
    .NUM_RECT(NR), .ADDR_W(AW)
  ) dut (
    .iVGA_CLK     (clk),
    .iRST_n       (rst_n),
    .fb           (fb),
    .pal_wr_en    (pal_wr_en),
    .pal_wr_idx   (pal_wr_idx),
    .pal_wr_bgr   (pal_wr_bgr),
    .rect_wr_en   (rect_wr_en),
    .rect_wr_sel  (rect_wr_sel),
    .rect_wr_data (rect_wr_data),
    .oHS          (oHS),
    .oVS          (oVS),
    .oBLANK_n     (oBLANK_n),
    .b_data       (b_data),
    .g_data       (g_data),
    .r_data       (r_data),
    .frame_start  (frame_start)
  );

  function automatic logic [IW-1:0] fbv(input logic [AW-1:0] a);
    return a[2:0] ^ a[5:3];
  endfunction

  // Framebuffer with a fixed RL-cycle read latency.
  logic [AW-1:0] fbq [RL];
  initial for (int i = 0; i < RL; i++) fbq[i] = '0;
  always @(posedge clk) begin
    fbq[0] <= fb.fb_rd_addr;
    for (int i = 1; i < RL; i++) fbq[i] <= fbq[i-1];
  end
  assign fb.fb_rd_data = fbv(fbq[RL-1]);

  int n_cmp = 0;
  int n_bad = 0;
  int t;
  int run;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s run=%0d t=%0d got=%0h exp=%0h",
               tag, run, t, got, exp);
    end
  endtask

  logic [3*CWD-1:0] m_pal_sh [8];
  logic [3*CWD-1:0] m_pal_lv [8];
  logic [RW-1:0]    m_rect_sh [NR];
  logic [RW-1:0]    m_rect_lv [NR];
  logic [3*CWD-1:0] exp_col [16];

  task automatic m_clear();
    for (int i = 0; i < 8; i++) begin
      m_pal_sh[i] = '0;
      m_pal_lv[i] = '0;
    end
    for (int i = 0; i < NR; i++) begin
      m_rect_sh[i] = '0;
      m_rect_lv[i] = '0;
    end
  endtask

  function automatic int exp_addr(input int x, input int y);
`ifdef VGA_SCAN_DOUBLE_EN
    return (y / 2) * (HA / 2) + (x / 2);
`else
    return y * HA + x;
`endif
  endfunction

  function automatic logic [IW-1:0] m_idx(input int x, input int y);
    logic en;
    logic [9:0] x0, y0, x1, y1;
    logic [IW-1:0] ix;
    for (int i = 0; i < NR; i++) begin
      {en, x0, y0, x1, y1, ix} = m_rect_lv[i];
      if (en && x >= int'(x0) && x <= int'(x1) &&
          y >= int'(y0) && y <= int'(y1))
        return ix;
    end
    return fbv(AW'(exp_addr(x, y)));
  endfunction

  task automatic rst_chk(input string tag);
    chk({tag, "_hs"},    32'(oHS), 32'(1));
    chk({tag, "_vs"},    32'(oVS), 32'(1));
    chk({tag, "_blank"}, 32'(oBLANK_n), 32'(0));
    chk({tag, "_rgb"},   32'({b_data, g_data, r_data}), 32'(0));
    chk({tag, "_rden"},  32'(fb.fb_rd_en), 32'(0));
    chk({tag, "_addr"},  32'(fb.fb_rd_addr), 32'(0));
    chk({tag, "_fs"},    32'(frame_start), 32'(0));
  endtask

  task automatic cyc();
    int x, y, p, qx, qy;
    logic act, cm;
    logic ehs, evs, ebl;
    logic [3*CWD-1:0] ecol;
    logic [9:0] x0, y0, x1, y1;
    @(negedge clk);
    x   = t % HT;
    y   = (t / HT) % VT;
    act = (x < HA) && (y < VA);
    cm  = (x == 0) && (y == VA);
    chk("rd_en", 32'(fb.fb_rd_en), 32'(act));
    if (act)
      chk("rd_addr", 32'(fb.fb_rd_addr), 32'(exp_addr(x, y)));
    chk("frame_start", 32'(frame_start), 32'(cm));
    exp_col[t % 16] = act ? m_pal_lv[m_idx(x, y)] : '0;
    p = t - L;
    if (p < 0) begin
      ehs = 1'b1; evs = 1'b1; ebl = 1'b0; ecol = '0;
    end else begin
      qx   = p % HT;
      qy   = (p / HT) % VT;
      ehs  = !(qx >= HA + HF && qx < HA + HF + HS);
      evs  = !(qy >= VA + VF && qy < VA + VF + VS);
      ebl  = (qx < HA) && (qy < VA);
      ecol = exp_col[p % 16];
    end
    chk("hs", 32'(oHS), 32'(ehs));
    chk("vs", 32'(oVS), 32'(evs));
    chk("blank_n", 32'(oBLANK_n), 32'(ebl));
    chk("rgb", 32'({b_data, g_data, r_data}), 32'(ecol));

    pal_wr_en  = 1'b0;
    rect_wr_en = 1'b0;
    if (cm || $urandom_range(0, 15) == 0) begin
      pal_wr_en  = 1'b1;
      pal_wr_idx = IW'($urandom);
      pal_wr_bgr = (3*CWD)'($urandom);
    end
    if (run == 0 && t == 100) begin
      rect_wr_en   = 1'b1;
      rect_wr_sel  = 3'd0;
      rect_wr_data = {1'b1, 10'd10, 10'd10, 10'd12, 10'd12, 3'd7};
    end else if (run == 0 && t == 101) begin
      rect_wr_en   = 1'b1;
      rect_wr_sel  = 3'd1;
      rect_wr_data = {1'b1, 10'd11, 10'd11, 10'd20, 10'd20, 3'd2};
    end else if ((run != 0 || t >= 2 * FR) &&
                 $urandom_range(0, 47) == 0) begin
      x0 = 10'($urandom_range(0, 45));
      y0 = 10'($urandom_range(0, 35));
      x1 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 45))
                                       : x0 + 10'($urandom_range(0, 15));
      y1 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 35))
                                       : y0 + 10'($urandom_range(0, 12));
      rect_wr_en   = 1'b1;
      rect_wr_sel  = 3'($urandom_range(0, 7));
      rect_wr_data = {1'($urandom_range(0, 3) != 0), x0, y0, x1, y1,
                      IW'($urandom)};
    end

    if (cm) begin
      for (int i = 0; i < 8; i++) m_pal_lv[i] = m_pal_sh[i];
      for (int i = 0; i < NR; i++) m_rect_lv[i] = m_rect_sh[i];
    end
    if (pal_wr_en) m_pal_sh[pal_wr_idx] = pal_wr_bgr;
    if (rect_wr_en && int'(rect_wr_sel) < NR)
      m_rect_sh[rect_wr_sel] = rect_wr_data;
    t++;
  endtask

  initial begin
    pal_wr_en    = 1'b0;
    pal_wr_idx   = '0;
    pal_wr_bgr   = '0;
    rect_wr_en   = 1'b0;
    rect_wr_sel  = '0;
    rect_wr_data = '0;
    run = 0;
    t   = 0;
    m_clear();
    repeat (3) @(posedge clk);
    #1 rst_chk("rst0");
    #1 rst_n = 1'b1;

    repeat (3 * FR + 20 * HT + 30) cyc();

    pal_wr_en  = 1'b0;
    rect_wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_chk("rst_mid");
    m_clear();
    run = 1;
    t   = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    repeat (3 * FR) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_scan_pipeline.md
# vga_scan_pipeline

Parametrised VGA scan-out engine for the display path: generates horizontal/vertical timing, fetches a palette index per active pixel from an external index framebuffer, and resolves colour through a writable palette. It adds up to NUM_RECT solid-colour overlay rectangles. Palette and rectangle updates are double-buffered and commit at frame boundaries, so they never tear. It replaces the fixed 640x480 address/colour-table path and feeds the VGA DAC pins directly.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- IDX_W, 3, palette index width; palette depth is 2^IDX_W
- COLOR_W, 8, bits per colour channel
- RD_LAT, 2, framebuffer read latency in cycles (1..4)
- NUM_RECT, 4, overlay rectangle count (1..8)
- ADDR_W, 19, framebuffer address width

Ports:
- iVGA_CLK  in  1  pixel clock; all logic on the rising edge
- iRST_n  in  1  asynchronous active-low reset
- fb_rd_addr  out  ADDR_W  framebuffer read address
- fb_rd_en  out  1  high on cycles that issue a valid read
- fb_rd_data  in  IDX_W  index returned RD_LAT cycles after the read
- pal_wr_en  in  1  palette shadow write strobe
- pal_wr_idx  in  IDX_W  palette entry to write
- pal_wr_bgr  in  3*COLOR_W  {b,g,r} value
- rect_wr_en  in  1  rectangle shadow write strobe
- rect_wr_sel  in  3  rectangle number; values >= NUM_RECT are ignored
- rect_wr_data  in  41+IDX_W  {en, x0[9:0], y0[9:0], x1[9:0], y1[9:0], idx}
- oHS, oVS  out  1  active-low syncs
- oBLANK_n  out  1  high during visible pixels
- b_data, g_data, r_data  out  COLOR_W  colour channels
- frame_start  out  1  one-cycle pulse on the commit cycle

## Operation

- Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1). h_cnt wraps to 0 and increments v_cnt; v_cnt wraps to 0 at V_TOTAL.
- The active region is h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. Sync is low while the counter is within [ACTIVE+FP, ACTIVE+FP+SYNC).
- Address generation is incremental; the block contains no multiplier:
  - The address register resets to 0 at h_cnt=0, v_cnt=0.
  - It increments after each active pixel.
  - fb_rd_en equals the active flag.
- Palette: 2^IDX_W shadow entries and 2^IDX_W live entries. pal_wr_en writes the shadow only.
- Rectangles: NUM_RECT shadow and live entries. A rectangle hits when en=1, x0<=x<=x1 and y0<=y<=y1. If x0>x1 or y0>y1, it never hits.
- Commit cycle is h_cnt=0, v_cnt=V_ACTIVE (first blank line). On this cycle:
  - All shadow entries copy to live.
  - frame_start pulses.
- A shadow write on the commit cycle itself lands in the shadow. It reaches live at the next commit.
- Colour resolution:
  - Lowest-numbered hitting rectangle wins; its idx replaces fb_rd_data.
  - The chosen index looks up the live palette.
  - Outside the active region, colour outputs are forced to 0.
- Reset mid-frame: all counters, the pipeline and the live/shadow state clear immediately. Scan restarts at (0,0).

## Timing

- Pipeline latency is L = RD_LAT+1 cycles:
  - RD_LAT cycles for the framebuffer read.
  - One registered palette stage.
- oHS, oVS, oBLANK_n and rectangle hit flags are delayed L cycles so they align with colour.
- The colour for pixel (x,y) appears on outputs L cycles after h_cnt=x, v_cnt=y.
- Reset values:
  - Counters, fb_rd_addr and all colour outputs are 0.
  - fb_rd_en=0, oBLANK_n=0, oHS=1, oVS=1, frame_start=0.
  - All palette entries are 0; all rectangles are disabled.
- Throughput: one pixel per clock, no stalls. The framebuffer must honour fixed RD_LAT.

## Configuration

- VGA_SCAN_DOUBLE_EN defined: 2x pixel doubling.
  - fb_rd_addr = (y>>1)*(H_ACTIVE/2) + (x>>1).
  - Generated by a line-base register that advances by H_ACTIVE/2 after every odd line.
  - Rectangle coordinates remain in full-resolution screen space.
- Undefined: fb_rd_addr = y*H_ACTIVE + x (linear).

## Test plan

- Reset release at defaults -> first oHS low at cycle 656+L. H period is 800 cycles; V period is 525 lines. oVS is low for exactly 1600 cycles.
- Framebuffer model returning addr[2:0], palette i={8*i,8*i,8*i} -> pixel (5,0) outputs 40/40/40 at cycle 5+L. Pixel (0,1) fetch address is 640.
- Rect0 {1,10,10,12,12,idx 7} and rect1 {1,11,11,20,20,idx 2} written mid-frame -> no effect until after the commit. In the next frame, (11,11) uses palette[7], (15,15) uses palette[2], and (9,9) uses the framebuffer index.
- pal_wr_en on the exact commit cycle -> the old value is shown for one more frame; the new value appears after the following frame_start.
- iRST_n pulsed low at (300,200) -> outputs reach reset values asynchronously; after release the scan resumes from (0,0) with address 0.
- VGA_SCAN_DOUBLE_EN defined -> pixels (0,0),(1,0),(0,1),(1,1) all read address 0; (2,2) reads 321.
